// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and the request record used by the register-file write arbiter.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback, long-latency return and register-file write bus around the arbiter.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0]     wb_data;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_reg;
  logic [DATA_W-1:0]     lu_data;
  logic                  rf_write_en;
  logic [REG_ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0]     rf_write_data;

  modport master (
    output wb_en, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
    input  lu_ready, rf_write_en, rf_write_reg, rf_write_data
  );
  modport slave (
    input  wb_en, wb_reg, wb_data, lu_valid, lu_reg, lu_data,
    output lu_ready, rf_write_en, rf_write_reg, rf_write_data
  );
endinterface

// File: rtl/regfile_write_arbiter_fifo.sv
// Small synchronous FIFO buffering long-latency write requests; head is the oldest entry.
module wr_req_fifo
  import regfile_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  wr_req_t din_i,
  output wr_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QDEPTH);

  wr_req_t          mem_q [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between writeback and a buffered long-latency
// return path, with starvation forcing and a pending-register scoreboard for decode.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_write_arbiter_if.slave bus,
  input  logic                   sb_set_en,
  input  logic [REG_ADDR_W-1:0]  sb_set_reg,
  input  logic [REG_ADDR_W-1:0]  chk_rs,
  input  logic [REG_ADDR_W-1:0]  chk_rt,
  input  logic [REG_ADDR_W-1:0]  chk_rd,
  output logic                   hazard,
  output logic                   starve_stall,
  output logic                   wb_drop_err
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  wr_req_t    head, lu_req;
  logic       full, empty, push, pop;
  logic       prim_act, grant_fifo;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic       starve_stall_q, starve_stall_d;
  logic       drop_err_q;
  logic [31:0] pend_q, pend_d;

  assign lu_req = '{waddr: bus.lu_reg, data: bus.lu_data};

  wr_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (lu_req),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Ready depends only on stored occupancy, so it never waits on this cycle's pop.
  assign bus.lu_ready = rst_n && !full;
  assign push = bus.lu_valid && bus.lu_ready && (bus.lu_reg != REG_ZERO);

  assign prim_act   = bus.wb_en && (bus.wb_reg != REG_ZERO);
  assign grant_fifo = !empty && (starve_stall_q || !prim_act);
  assign pop        = grant_fifo;

  assign bus.rf_write_en   = grant_fifo || prim_act;
  assign bus.rf_write_reg  = grant_fifo ? head.waddr : bus.wb_reg;
  assign bus.rf_write_data = grant_fifo ? head.data  : bus.wb_data;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (empty || pop)               starve_cnt_d = '0;
    else if (starve_cnt_q != CNT_MAX) starve_cnt_d = starve_cnt_q + 1'b1;

    starve_stall_d = starve_stall_q;
    if (pop)                         starve_stall_d = 1'b0;
    else if (starve_cnt_d == CNT_MAX) starve_stall_d = 1'b1;

    // Clear before set so an issue to the same register in the same cycle wins.
    pend_d = pend_q;
    if (grant_fifo) pend_d[head.waddr] = 1'b0;
    if (sb_set_en && (sb_set_reg != REG_ZERO)) pend_d[sb_set_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q   <= '0;
      starve_stall_q <= 1'b0;
      drop_err_q     <= 1'b0;
      pend_q         <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      starve_stall_q <= starve_stall_d;
      pend_q         <= pend_d;
      if (grant_fifo && prim_act) drop_err_q <= 1'b1;
    end
  end

  assign hazard       = pend_q[chk_rs] | pend_q[chk_rt] | pend_q[chk_rd];
  assign starve_stall = starve_stall_q;
  assign wb_drop_err  = drop_err_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sb_set_en;
  logic [4:0] sb_set_reg, chk_rs, chk_rt, chk_rd;
  logic hazard, starve_stall, wb_drop_err;
  int n_cmp = 0;
  int n_bad = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .sb_set_en    (sb_set_en),
    .sb_set_reg   (sb_set_reg),
    .chk_rs       (chk_rs),
    .chk_rt       (chk_rt),
    .chk_rd       (chk_rd),
    .hazard       (hazard),
    .starve_stall (starve_stall),
    .wb_drop_err  (wb_drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wb_en = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = '0;
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd7; bus.lu_data = 32'h77;
    sb_set_en = 1'b1; sb_set_reg = 5'd7;
    chk_rs = 5'd7; chk_rt = 5'd0; chk_rd = 5'd0;

    // Reset with requests active
    tick(); tick();
    chk("rst_lu_ready", 32'(bus.lu_ready), 32'd0);
    chk("rst_rf_en", 32'(bus.rf_write_en), 32'd0);
    chk("rst_stall", 32'(starve_stall), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    bus.lu_valid = 1'b0; sb_set_en = 1'b0; rst_n = 1'b1;
    tick();
    chk("rel_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("rel_hazard", 32'(hazard), 32'd0);
    chk("rel_rf_en", 32'(bus.rf_write_en), 32'd0);

    // Primary passthrough
    bus.wb_en = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'hDEADBEEF;
    #1;
    chk("prim_en", 32'(bus.rf_write_en), 32'd1);
    chk("prim_reg", 32'(bus.rf_write_reg), 32'd5);
    chk("prim_data", bus.rf_write_data, 32'hDEADBEEF);
    bus.wb_reg = 5'd0;
    #1;
    chk("prim_r0_en", 32'(bus.rf_write_en), 32'd0);
    bus.wb_en = 1'b0;

    // Secondary request with scoreboard
    sb_set_en = 1'b1; sb_set_reg = 5'd9;
    tick();
    sb_set_en = 1'b0; chk_rs = 5'd9;
    #1;
    chk("sb_hazard_set", 32'(hazard), 32'd1);
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd9; bus.lu_data = 32'h1234;
    #1;
    chk("sec_ready", 32'(bus.lu_ready), 32'd1);
    chk("sec_no_bypass", 32'(bus.rf_write_en), 32'd0);
    tick();
    bus.lu_valid = 1'b0;
    chk("sec_en", 32'(bus.rf_write_en), 32'd1);
    chk("sec_reg", 32'(bus.rf_write_reg), 32'd9);
    chk("sec_data", bus.rf_write_data, 32'h1234);
    chk("sec_hazard_hold", 32'(hazard), 32'd1);
    tick();
    chk("sec_hazard_clr", 32'(hazard), 32'd0);
    chk("sec_idle", 32'(bus.rf_write_en), 32'd0);
    chk_rs = 5'd0;

    // Fill, drain in order, three times for pointer wrap
    for (int rep = 0; rep < 3; rep++) begin
      bus.wb_en = 1'b1; bus.wb_reg = 5'd20; bus.wb_data = 32'hAAAA0000 + rep;
      bus.lu_valid = 1'b1; bus.lu_reg = 5'd1; bus.lu_data = 32'h100 + rep;
      tick();
      bus.lu_reg = 5'd2; bus.lu_data = 32'h200 + rep;
      #1;
      chk("fill_ready1", 32'(bus.lu_ready), 32'd1);
      tick();
      bus.lu_valid = 1'b0;
      chk("fill_full", 32'(bus.lu_ready), 32'd0);
      chk("fill_prim_reg", 32'(bus.rf_write_reg), 32'd20);
      bus.wb_en = 1'b0;
      #1;
      chk("drain1_reg", 32'(bus.rf_write_reg), 32'd1);
      chk("drain1_data", bus.rf_write_data, 32'h100 + rep);
      tick();
      chk("drain2_reg", 32'(bus.rf_write_reg), 32'd2);
      chk("drain2_data", bus.rf_write_data, 32'h200 + rep);
      tick();
      chk("drain_ready", 32'(bus.lu_ready), 32'd1);
      chk("drain_idle", 32'(bus.rf_write_en), 32'd0);
    end

    // Starvation under continuous primary traffic
    bus.wb_en = 1'b1; bus.wb_reg = 5'd21; bus.wb_data = 32'h2121;
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd3; bus.lu_data = 32'h333;
    tick();
    bus.lu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("starve_wait_stall", 32'(starve_stall), 32'd0);
      chk("starve_wait_reg", 32'(bus.rf_write_reg), 32'd21);
      tick();
    end
    chk("starve_stall_up", 32'(starve_stall), 32'd1);
    chk("starve_grant_reg", 32'(bus.rf_write_reg), 32'd3);
    chk("starve_grant_data", bus.rf_write_data, 32'h333);
    chk("starve_err_pre", 32'(wb_drop_err), 32'd0);
    tick();
    chk("starve_err_set", 32'(wb_drop_err), 32'd1);
    chk("starve_stall_clr", 32'(starve_stall), 32'd0);
    chk("starve_prim_back", 32'(bus.rf_write_reg), 32'd21);
    bus.wb_en = 1'b0;
    tick(); tick();
    chk("starve_err_sticky", 32'(wb_drop_err), 32'd1);

    // Same-register set and clear: set wins
    sb_set_en = 1'b1; sb_set_reg = 5'd4;
    tick();
    sb_set_en = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd4; bus.lu_data = 32'h444;
    tick();
    bus.lu_valid = 1'b0;
    sb_set_en = 1'b1; sb_set_reg = 5'd4;
    chk("coll_grant_reg", 32'(bus.rf_write_reg), 32'd4);
    tick();
    sb_set_en = 1'b0; chk_rt = 5'd4;
    #1;
    chk("coll_hazard", 32'(hazard), 32'd1);
    chk("coll_popped", 32'(bus.rf_write_en), 32'd0);
    chk_rt = 5'd0;

    // Register-0 handshake completes but is not queued
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd0; bus.lu_data = 32'hFFFF;
    #1;
    chk("r0_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    bus.lu_valid = 1'b0;
    chk("r0_not_queued", 32'(bus.rf_write_en), 32'd0);

    // Reset mid-operation discards queued entry
    bus.lu_valid = 1'b1; bus.lu_reg = 5'd6; bus.lu_data = 32'h666;
    bus.wb_en = 1'b1; bus.wb_reg = 5'd22;
    tick();
    bus.lu_valid = 1'b0; bus.wb_en = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_no_write", 32'(bus.rf_write_en), 32'd0);
    chk("midrst_err_clr", 32'(wb_drop_err), 32'd0);
    chk_rt = 5'd4;
    #1;
    chk("midrst_pend_clr", 32'(hazard), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
